// File: rtl/ehgu_ram_rd_pkg.sv
// ehgu_ram_rd_pkg: shared types and constants for the ehgu RAM stream reader.
//   rd_state_e  : reader FSM states (IDLE, RUN, DRAIN, DONE)
//   STALL_CNT_W : width of the optional stall counter output
package ehgu_ram_rd_pkg;

    localparam int STALL_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_e;

endpackage

// File: rtl/ehgu_sync_fifo.sv
// ehgu_sync_fifo: small synchronous FIFO with occupancy count.
// DEPTH need not be a power of two; pointers wrap explicitly.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (dropped if full and not popping)
//   i_data     : write data
//   i_pop      : consume head entry (ignored when empty)
//   o_data     : head entry, valid while !o_empty
//   o_full     : all DEPTH entries occupied
//   o_empty    : no entries
//   o_count    : current occupancy 0..DEPTH
// A simultaneous push and pop leaves the count unchanged; both take effect.
module ehgu_sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p >= PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is accepted only when the head leaves this cycle.
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage is not reset; the count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ehgu_ram_stream_reader.sv
// ehgu_ram_stream_reader: read-side master for the ehgu dual-port RAM.
// Takes a (base_addr, len) block command, reads len words from the RAM read
// port (address wraps DEPTH-1 -> 0) and returns them as a valid/ready stream
// with out_last on the final word.
// Optional build macro: EHGU_RAM_RD_STALL_CNT_EN adds output stall_cnt.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   start, base_addr, len: command strobe (sampled only when idle) and fields
//   busy                 : command in progress (RUN, DRAIN, DONE)
//   done                 : one-cycle pulse at end of command
//   renable, raddr       : RAM read port request
//   rdata                : RAM read data, valid the cycle after renable
//   out_valid/out_ready  : stream handshake
//   out_data, out_last   : stream payload and final-beat marker
//   stall_cnt            : (macro only) cycles with out_valid & !out_ready
//   dbg_state            : current FSM state
// Handshake: a beat transfers on a cycle where out_valid && out_ready; once
// out_valid is high, out_valid, out_data and out_last hold until that cycle.
module ehgu_ram_stream_reader
    import ehgu_ram_rd_pkg::*;
#(
    parameter int DEPTH     = 3,
    parameter int WIDTH     = 8,
    parameter int LEN_W     = 8,
    parameter int BUF_DEPTH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(BUF_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    base_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             renable,
    output logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
`ifdef EHGU_RAM_RD_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0] stall_cnt,
`endif
    output logic [1:0]       dbg_state
);

    rd_state_e        r_state;
    logic [AW-1:0]    r_addr;
    logic [LEN_W-1:0] r_remaining;
    logic             r_inflight;       // read issued last cycle; rdata valid now
    logic             r_inflight_last;  // that read was the len-th word

    logic             w_issue;
    logic             w_pop;
    logic             w_accept;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [CW-1:0]    w_fifo_count;
    logic [WIDTH:0]   w_fifo_data;

    // Credit check: words already buffered plus the one still in the RAM
    // register must leave room for the word this issue will produce.
    assign w_issue = (r_state == RUN) && (r_remaining != '0) && !w_fifo_full &&
                     ((int'(w_fifo_count) + int'(r_inflight)) < BUF_DEPTH);

    assign w_pop    = out_valid && out_ready;
    assign w_accept = (r_state == IDLE) && start;

    assign renable   = w_issue;
    assign raddr     = w_issue ? r_addr : '0;
    assign busy      = (r_state != IDLE);
    assign done      = (r_state == DONE);
    assign dbg_state = r_state;

    // Gate the head entry so the stream shows zeros, not stale storage, when empty.
    assign out_valid = !w_fifo_empty;
    assign out_data  = w_fifo_empty ? '0 : w_fifo_data[WIDTH-1:0];
    assign out_last  = !w_fifo_empty && w_fifo_data[WIDTH];

    ehgu_sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  ({r_inflight_last, rdata}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_addr          <= '0;
            r_remaining     <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            // rdata is only captured the cycle after an issue; otherwise the
            // RAM output is undefined and must not reach the FIFO.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == LEN_W'(1));

            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            r_state     <= RUN;
                            r_addr      <= base_addr;
                            r_remaining <= len;
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (w_issue) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_addr      <= (r_addr >= AW'(DEPTH - 1)) ? '0 : r_addr + AW'(1);
                        if (r_remaining == LEN_W'(1)) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_pop && out_last) begin
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

`ifdef EHGU_RAM_RD_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if (busy && out_valid && !out_ready && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    logic w_accept_unused;
    assign w_accept_unused = w_accept;
`endif

endmodule

// File: tb/tb_ehgu_ram_stream_reader.sv
module tb_ehgu_ram_stream_reader;

    localparam int DEPTH     = 3;
    localparam int WIDTH     = 8;
    localparam int LEN_W     = 8;
    localparam int BUF_DEPTH = 4;
    localparam int AW        = 2;

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic             busy;
    logic             done;
    logic             renable;
    logic [AW-1:0]    raddr;
    logic [WIDTH-1:0] rdata = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic [1:0]       dbg_state;
`ifdef EHGU_RAM_RD_STALL_CNT_EN
    logic [15:0]      stall_cnt;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ehgu_ram_stream_reader #(
        .DEPTH     (DEPTH),
        .WIDTH     (WIDTH),
        .LEN_W     (LEN_W),
        .BUF_DEPTH (BUF_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .renable   (renable),
        .raddr     (raddr),
        .rdata     (rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
`ifdef EHGU_RAM_RD_STALL_CNT_EN
        .stall_cnt (stall_cnt),
`endif
        .dbg_state (dbg_state)
    );

    // RAM contents {A0, A1, A2}; registered read, garbage when not enabled.
    logic [WIDTH-1:0] ram [DEPTH];
    initial begin
        ram[0] = 8'hA0;
        ram[1] = 8'hA1;
        ram[2] = 8'hA2;
    end
    always @(posedge clk) begin
        if (renable) rdata <= ram[raddr];
        else         rdata <= 8'h5C;
    end

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [WIDTH:0] exp_q[$];
    int ren_cyc[$];
    int raddr_log[$];
    int beat_cyc[$];
    int done_cyc[$];
    int valid_cnt = 0;
    int issued = 0;
    int popped = 0;
    int max_out = 0;
    logic held_v = 1'b0;
    logic [WIDTH:0] held_d = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests_run++;
        tests_failed++;
        $display("FAIL %s: bound expired", name);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            held_v = 1'b0;
        end else begin
            if (renable) begin
                ren_cyc.push_back(cyc);
                raddr_log.push_back(int'(raddr));
                issued++;
            end
            if (done) done_cyc.push_back(cyc);
            if (out_valid) valid_cnt++;
            if (held_v) check("hold_stable", 32'({out_valid, out_last, out_data}), 32'({1'b1, held_d}));
            if (out_valid && out_ready) begin
                beat_cyc.push_back(cyc);
                popped++;
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got %0h expected no beat", {out_last, out_data});
                end else begin
                    check("beat", 32'({out_last, out_data}), 32'(exp_q.pop_front()));
                end
            end
            if (issued - popped > max_out) max_out = issued - popped;
            held_v = out_valid && !out_ready;
            held_d = {out_last, out_data};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_logs();
        ren_cyc.delete();
        raddr_log.delete();
        beat_cyc.delete();
        done_cyc.delete();
        valid_cnt = 0;
        issued = 0;
        popped = 0;
        max_out = 0;
    endtask

    task automatic push_exp(input int b, input int n);
        logic [WIDTH:0] e;
        for (int i = 0; i < n; i++) begin
            e = {(i == n - 1), ram[(b + i) % DEPTH]};
            exp_q.push_back(e);
        end
    endtask

    // Called just after a rising edge; start is high for the current cycle n0.
    task automatic do_start(input int b, input int l, output int n0);
        base_addr = AW'(b);
        len = LEN_W'(l);
        start = 1'b1;
        n0 = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) fail_now(name);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_busy_after"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"}, 32'(busy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_renable"}, 32'(renable), 32'd0);
        check({name, "_raddr"}, 32'(raddr), 32'd0);
        check({name, "_out_valid"}, 32'(out_valid), 32'd0);
        check({name, "_out_last"}, 32'(out_last), 32'd0);
        check({name, "_out_data"}, 32'(out_data), 32'd0);
        check({name, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    task automatic run_basic(input string name);
        int n0;
        clear_logs();
        push_exp(0, 3);
        do_start(0, 3, n0);
        wait_done(name);
        check({name, "_ren_count"}, 32'(ren_cyc.size()), 32'd3);
        if (ren_cyc.size() >= 3) begin
            check({name, "_ren_first"}, 32'(ren_cyc[0]), 32'(n0 + 1));
            check({name, "_ren_last"}, 32'(ren_cyc[2]), 32'(n0 + 3));
        end
        check({name, "_beat_count"}, 32'(beat_cyc.size()), 32'd3);
        if (beat_cyc.size() >= 3) begin
            check({name, "_beat_first"}, 32'(beat_cyc[0]), 32'(n0 + 3));
            check({name, "_beat_last"}, 32'(beat_cyc[2]), 32'(n0 + 5));
        end
        check({name, "_done_count"}, 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() >= 1) check({name, "_done_cycle"}, 32'(done_cyc[0]), 32'(n0 + 6));
        check({name, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic read of all three words.
        run_basic("basic");

        // Wrap-around: 2,0,1,2.
        clear_logs();
        push_exp(2, 4);
        do_start(2, 4, n0);
        wait_done("wrap");
        check("wrap_ren_count", 32'(raddr_log.size()), 32'd4);
        if (raddr_log.size() >= 4) begin
            check("wrap_raddr0", 32'(raddr_log[0]), 32'd2);
            check("wrap_raddr1", 32'(raddr_log[1]), 32'd0);
            check("wrap_raddr2", 32'(raddr_log[2]), 32'd1);
            check("wrap_raddr3", 32'(raddr_log[3]), 32'd2);
        end
        check("wrap_beat_count", 32'(beat_cyc.size()), 32'd4);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        // Backpressure: ready low for 10 cycles from the first valid.
        begin
            bit seen = 0;
            clear_logs();
            push_exp(0, 8);
            out_ready = 1'b0;
            do_start(0, 8, n0);
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = 1;
                    break;
                end
            end
            if (!seen) fail_now("bp_first_valid");
            for (int k = 0; k < 10; k++) @(posedge clk);
            #1 out_ready = 1'b1;
            wait_done("bp");
            check("bp_beat_count", 32'(beat_cyc.size()), 32'd8);
            check("bp_max_outstanding_ok", 32'(max_out <= BUF_DEPTH), 32'd1);
            check("bp_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef EHGU_RAM_RD_STALL_CNT_EN
            check("bp_stall_cnt", 32'(stall_cnt), 32'd10);
`endif
        end

        // Zero-length command.
        clear_logs();
        do_start(0, 0, n0);
        wait_done("len0");
        check("len0_done_count", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() >= 1) check("len0_done_cycle", 32'(done_cyc[0]), 32'(n0 + 1));
        check("len0_renable_count", 32'(ren_cyc.size()), 32'd0);
        check("len0_valid_count", 32'(valid_cnt), 32'd0);

        // Start re-pulsed while busy must be ignored.
        clear_logs();
        push_exp(0, 3);
        do_start(0, 3, n0);
        @(posedge clk);
        #1;
        base_addr = 2'd2;
        len = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("busy_start");
        repeat (4) @(posedge clk);
        #1;
        check("busy_start_beats", 32'(beat_cyc.size()), 32'd3);
        check("busy_start_ren", 32'(ren_cyc.size()), 32'd3);
        check("busy_start_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of RUN.
        clear_logs();
        push_exp(0, 8);
        do_start(0, 8, n0);
        @(posedge clk);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_basic("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ehgu_ram_stream_reader.md
Name: ehgu_ram_stream_reader

Overview:
- Read-side master for the ehgu dual-port RAM.
- Accepts a block-read command (base address, length) and issues renable/raddr to the RAM read port.
- Returns the RAM's 1-cycle registered read data as a valid/ready stream with out_last.
- Holds in-flight read data in a small internal FIFO so downstream backpressure never loses a word.

Parameters:
- DEPTH, 3, words in the attached RAM; need not be a power of two.
- WIDTH, 8, data width in bits.
- LEN_W, 8, width of the length field.
- BUF_DEPTH, 4, internal FIFO entries; minimum 3; value 4 gives full throughput.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  command strobe; sampled only in IDLE.
- base_addr  in  $clog2(DEPTH)  first RAM address to read.
- len  in  LEN_W  number of words to read.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at end of command.
- renable  out  1  to RAM read enable.
- raddr  out  $clog2(DEPTH)  to RAM read address.
- rdata  in  WIDTH  from RAM, valid the cycle after renable.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_data  out  WIDTH  stream data.
- out_last  out  1  marks final beat of the command.

Behaviour:
- Reset values: busy=0, done=0, renable=0, raddr=0, out_valid=0, out_last=0, out_data=0; FIFO empty; state IDLE.
- State IDLE:
  - start=1 with len>0 → RUN; latch addr=base_addr and remaining=len.
  - start=1 with len=0 → DONE; no RAM access.
- State RUN:
  - Issue a read when remaining>0 and (fifo_count + pending) < BUF_DEPTH. Issuing means renable=1, raddr=addr.
  - On issue: remaining decrements; addr increments, wrapping DEPTH-1 → 0 (compare against DEPTH, not a power of two). len>DEPTH re-reads wrapped words.
  - pending = reads issued whose data has not yet reached the FIFO; maximum 2.
  - rdata is written to the FIFO only in the cycle after an issue. In any other cycle rdata is ignored, because the RAM drives X when renable=0.
  - When remaining=0 and the last word has been issued → DRAIN.
- State DRAIN: wait until the final beat completes a handshake (out_valid & out_ready & out_last) → DONE.
- State DONE: done=1 for exactly one cycle → IDLE. busy=0 from the cycle after done.
- busy=1 in RUN, DRAIN and DONE.
- start while busy is ignored, not queued.
- Latency: start high in cycle N → renable high in cycle N+1 → out_valid high in cycle N+3 (RAM register, then FIFO register).
- Throughput: with out_ready held at 1, one beat per cycle after the first.
- Stream rules:
  - out_valid stays high and out_data/out_last stay stable until the handshake.
  - out_last is set on the beat whose FIFO entry was the len-th word read.
- Backpressure: the issue condition guarantees the FIFO never overflows and no read is issued whose data cannot be stored.
- Reset mid-operation: everything returns to reset values at once; in-flight RAM data is discarded.
- Simultaneous FIFO push and pop in the same cycle: count is unchanged and both operations take effect.

Optional Feature:
- Macro: EHGU_RAM_RD_STALL_CNT_EN.
- Defined: adds output port stall_cnt, 16 bits.
  - Counts cycles with out_valid=1 and out_ready=0 during the current command.
  - Saturates at 16'hFFFF.
  - Clears to 0 when a command is accepted.
  - Holds its value after done.
  - Resets to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Package ehgu_ram_rd_pkg:
  - state enum rd_state_e {IDLE, RUN, DRAIN, DONE}.
  - STALL_CNT_W = 16.
- Sub-module ehgu_sync_fifo:
  - Parameters WIDTH+1 and BUF_DEPTH; the extra bit carries last.
  - Ports push/pop/full/empty/count; same clk/rst_n.
  - The reader owns issue and credit logic only.

Test Plan:
- DEPTH=3, RAM preloaded with {A0,A1,A2}; start, base_addr=0, len=3, out_ready=1 → renable in cycles N+1..N+3; beats A0,A1,A2 in cycles N+3..N+5; out_last on A2; done in cycle N+6.
- Wrap-around: base_addr=2, len=4 → beats A2,A0,A1,A2; raddr sequence 2,0,1,2.
- Backpressure: len=8, out_ready low for 10 cycles after first valid, then high → out_valid/out_data held stable while low; no more than BUF_DEPTH entries outstanding; all 8 beats in order; no X on out_data.
- len=0 → done pulses in cycle N+1; renable never asserted; out_valid stays 0.
- start re-pulsed while busy, with different base_addr → ignored; output is the original sequence only.
- Reset: rst_n low in mid-RUN → outputs immediately at reset values; the next command after release runs cleanly. With the macro defined, stall_cnt reads 10 after the backpressure test.
